// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: destination addresses, port count
// and the default stall timeout used by the sync stage.
package router_pkg;

  localparam logic [1:0] ADDR_0   = 2'd0;
  localparam logic [1:0] ADDR_1   = 2'd1;
  localparam logic [1:0] ADDR_2   = 2'd2;
  localparam logic [1:0] ADDR_INV = 2'd3;

  localparam int DEFAULT_TIMEOUT = 30;
  localparam int NUM_PORTS       = 3;

endpackage

// File: rtl/router_sync_timer.sv
// Per-port stall timer: pulses soft_reset for one cycle once a destination
// has left valid data unread for TIMEOUT consecutive edges.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic vld_out,
  input  logic read_enb,
  output logic soft_reset
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;

  // A read on the expiry edge wins over the pulse and restarts the count.
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    soft_reset_d = 1'b0;
    if (!vld_out || read_enb) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d        = '0;
      soft_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync.sv
// Glue between router_fsm and the three output FIFOs: latches the packet
// destination, steers write strobes and full flags, and times out stalls.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  logic [1:0]           addr_q, addr_d;
  logic [1:0]           sel;
  logic [NUM_PORTS-1:0] vld, rd, sr;

  always_comb begin
    addr_d = addr_q;
    if (detect_add) addr_d = data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) addr_q <= ADDR_0;
    else       addr_q <= addr_d;
  end

  // The FSM checks fullness while still decoding the header, so the live
  // address is used ahead of the latched one.
  always_comb begin
    sel       = detect_add ? data_in : addr_q;
    fifo_full = 1'b0;
    case (sel)
      ADDR_0:  fifo_full = full_0;
      ADDR_1:  fifo_full = full_1;
      ADDR_2:  fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      case (addr_q)
        ADDR_0:  write_enb = 3'b001;
        ADDR_1:  write_enb = 3'b010;
        ADDR_2:  write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end
  end

  assign vld       = {~empty_2, ~empty_1, ~empty_0};
  assign rd        = {read_enb_2, read_enb_1, read_enb_0};
  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .vld_out    (vld[i]),
      .read_enb   (rd[i]),
      .soft_reset (sr[i])
    );
  end

  assign soft_reset_0 = sr[0];
  assign soft_reset_1 = sr[1];
  assign soft_reset_2 = sr[2];

endmodule
